// File: rtl/div_result_sequencer.sv
// rtl/div_result_sequencer.sv - timed 7-segment display sequencer for packed divider results
// Optional feature macro: DIV_SEQ_REPEAT_EN (loop the current result instead of returning to IDLE)
module div_result_sequencer #(
  parameter int               CNT_W = 24,
  parameter logic [CNT_W-1:0] DWELL = 24'd5000000,
  parameter logic [CNT_W-1:0] GAP   = 24'd1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] res_in,
  input  logic       res_valid,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy,
  output logic       ovf
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHOW_Q = 3'd1,
    GAP_Q  = 3'd2,
    SHOW_R = 3'd3,
    GAP_R  = 3'd4,
    SHOW_E = 3'd5,
    GAP_E  = 3'd6
  } state_t;

  localparam logic [7:0] ERR_CODE = 8'hFF;
  localparam logic [6:0] SEG_E    = 7'b1111001;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       cur;
  logic [7:0]       pend;
  logic             pend_v;

  // gfedcba pattern for one hex digit
  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  logic             show_st;
  logic [CNT_W-1:0] len;
  logic             last;
  logic             seq_end;
  logic             nxt_have;
  logic [7:0]       nxt_val;
  logic [7:0]       launch_val;
  state_t           launch_st;
  logic [6:0]       launch_seg;

  // Dwell/gap length of the current state and the exit / end-of-sequence conditions
  always_comb begin
    show_st  = (state == SHOW_Q) || (state == SHOW_R) || (state == SHOW_E);
    len      = show_st ? DWELL : GAP;
    last     = (cnt == len - 1'b1);
    seq_end  = last && ((state == GAP_R) || (state == GAP_E));
    nxt_have = pend_v | res_valid;
    nxt_val  = pend_v ? pend : res_in;
  end

  // First state and digit of a sequence: new strobe from IDLE, queued result, or a repeat of cur
  always_comb begin
    if (state == IDLE) launch_val = res_in;
    else if (nxt_have) launch_val = nxt_val;
    else               launch_val = cur;
    if (launch_val == ERR_CODE) begin
      launch_st  = SHOW_E;
      launch_seg = SEG_E;
    end else begin
      launch_st  = SHOW_Q;
      launch_seg = hex7(launch_val[7:4]);
    end
  end

  // Sequencer FSM with registered display outputs and the one-entry pending slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      cur    <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
      seg    <= '0;
      dp     <= 1'b0;
      busy   <= 1'b0;
      ovf    <= 1'b0;
    end else if (ena) begin
      if (state == IDLE) begin
        if (res_valid) begin
          cur   <= res_in;
          cnt   <= '0;
          state <= launch_st;
          seg   <= launch_seg;
          dp    <= 1'b0;
          busy  <= 1'b1;
        end
      end else begin
        if (!last) begin
          cnt <= cnt + 1'b1;
        end else begin
          cnt <= '0;
          case (state)
            SHOW_Q: begin
              state <= GAP_Q;
              seg   <= '0;
              dp    <= 1'b0;
            end
            GAP_Q: begin
              state <= SHOW_R;
              seg   <= hex7(cur[3:0]);
              dp    <= 1'b1;
            end
            SHOW_R: begin
              state <= GAP_R;
              seg   <= '0;
              dp    <= 1'b0;
            end
            SHOW_E: begin
              state <= GAP_E;
              seg   <= '0;
              dp    <= 1'b0;
            end
            GAP_R, GAP_E: begin
              if (nxt_have) begin
                // Go straight into the next result so no blank IDLE cycle appears
                cur   <= nxt_val;
                state <= launch_st;
                seg   <= launch_seg;
                dp    <= 1'b0;
              end else begin
`ifdef DIV_SEQ_REPEAT_EN
                state <= launch_st;
                seg   <= launch_seg;
                dp    <= 1'b0;
`else
                state <= IDLE;
                seg   <= '0;
                dp    <= 1'b0;
                busy  <= 1'b0;
`endif
              end
            end
            default: begin
              state <= IDLE;
              seg   <= '0;
              dp    <= 1'b0;
              busy  <= 1'b0;
            end
          endcase
        end

        if (seq_end && nxt_have) begin
          // The oldest result moves to cur; a strobe on this cycle refills the slot without overflow
          pend_v <= pend_v & res_valid;
          if (res_valid) pend <= res_in;
        end else if (res_valid) begin
          pend   <= res_in;
          pend_v <= 1'b1;
          if (pend_v) ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_result_sequencer.sv
// tb/tb_div_result_sequencer.sv - scoreboard bench for div_result_sequencer (DWELL=4, GAP=2)
module tb_div_result_sequencer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] res_in;
  logic       res_valid;
  logic [6:0] seg;
  logic       dp;
  logic       busy;
  logic       ovf;

  int tests;
  int fails;

  // each entry is the expected {busy, dp, seg} seen on one cycle
  logic [8:0] exp_q[$];
  logic [8:0] exp;
  logic [8:0] last_exp;
  logic       en_now;

  div_result_sequencer #(
    .CNT_W(24),
    .DWELL(24'd4),
    .GAP  (24'd2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .res_in   (res_in),
    .res_valid(res_valid),
    .seg      (seg),
    .dp       (dp),
    .busy     (busy),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] hex_ref(input logic [3:0] d);
    logic [6:0] t[16];
    t = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
          7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
          7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
          7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
    return t[d];
  endfunction

  task automatic push_seq(input logic [7:0] v);
    if (v == 8'hFF) begin
      repeat (4) exp_q.push_back({2'b10, 7'b1111001});
      repeat (2) exp_q.push_back(9'b100000000);
    end else begin
      repeat (4) exp_q.push_back({2'b10, hex_ref(v[7:4])});
      repeat (2) exp_q.push_back(9'b100000000);
      repeat (4) exp_q.push_back({2'b11, hex_ref(v[3:0])});
      repeat (2) exp_q.push_back(9'b100000000);
    end
  endtask

  task automatic do_reset();
    ena       = 1'b1;
    res_valid = 1'b0;
    res_in    = 8'h00;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({busy, dp, seg, ovf} !== 10'b0) begin
      fails++;
      $display("FAIL reset_outputs got %b want %b", {busy, dp, seg, ovf}, 10'b0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({busy, dp, seg} !== 9'b0) begin
        fails++;
        $display("FAIL reset_idle cycle %0d got %b want %b", i, {busy, dp, seg}, 9'b0);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      if (i == 0) begin res_in = 8'h32; res_valid = 1'b1; push_seq(8'h32); end
      @(negedge clk);
      res_valid = 1'b0;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'b0;
      tests++;
      if ({busy, dp, seg} !== exp) begin
        fails++;
        $display("FAIL single_32 cycle %0d got %b want %b", i, {busy, dp, seg}, exp);
      end
    end
  endtask

  task automatic test_error();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin res_in = 8'hFF; res_valid = 1'b1; push_seq(8'hFF); end
      @(negedge clk);
      res_valid = 1'b0;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'b0;
      tests++;
      if ({busy, dp, seg} !== exp) begin
        fails++;
        $display("FAIL error_E cycle %0d got %b want %b", i, {busy, dp, seg}, exp);
      end
    end
  endtask

  task automatic test_overwrite();
    do_reset();
    for (int i = 0; i < 26; i++) begin
      if (i == 0)  begin res_in = 8'h21; res_valid = 1'b1; push_seq(8'h21); end
      if (i == 2)  begin res_in = 8'h10; res_valid = 1'b1; end
      if (i == 11) begin res_in = 8'h05; res_valid = 1'b1; push_seq(8'h05); end
      @(negedge clk);
      res_valid = 1'b0;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'b0;
      tests++;
      if ({busy, dp, seg} !== exp) begin
        fails++;
        $display("FAIL overwrite cycle %0d got %b want %b", i, {busy, dp, seg}, exp);
      end
    end
    tests++;
    if (ovf !== 1'b1) begin
      fails++;
      $display("FAIL overwrite_ovf got %b want 1", ovf);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 38; i++) begin
      if (i == 0)  begin res_in = 8'h21; res_valid = 1'b1; push_seq(8'h21); end
      if (i == 3)  begin res_in = 8'h11; res_valid = 1'b1; push_seq(8'h11); end
      if (i == 12) begin res_in = 8'h40; res_valid = 1'b1; push_seq(8'h40); end
      @(negedge clk);
      res_valid = 1'b0;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'b0;
      tests++;
      if ({busy, dp, seg} !== exp) begin
        fails++;
        $display("FAIL back_to_back cycle %0d got %b want %b", i, {busy, dp, seg}, exp);
      end
    end
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL back_to_back_ovf got %b want 0", ovf);
    end
  endtask

  task automatic test_ena_and_reset();
    do_reset();
    last_exp = 9'b0;
    for (int i = 0; i < 17; i++) begin
      ena = !(i >= 7 && i <= 9);
      if (i == 0) begin res_in = 8'h32; res_valid = 1'b1; push_seq(8'h32); end
      if (i == 8) begin res_in = 8'h55; res_valid = 1'b1; end
      en_now = ena;
      @(negedge clk);
      res_valid = 1'b0;
      if (en_now) exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'b0;
      else        exp = last_exp;
      last_exp = exp;
      tests++;
      if ({busy, dp, seg} !== exp) begin
        fails++;
        $display("FAIL ena_freeze cycle %0d got %b want %b", i, {busy, dp, seg}, exp);
      end
    end
    ena = 1'b1;

    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin res_in = 8'h32; res_valid = 1'b1; push_seq(8'h32); end
      if (i == 2) begin res_in = 8'h44; res_valid = 1'b1; end
      @(negedge clk);
      res_valid = 1'b0;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'b0;
      tests++;
      if ({busy, dp, seg} !== exp) begin
        fails++;
        $display("FAIL pre_reset cycle %0d got %b want %b", i, {busy, dp, seg}, exp);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, dp, seg, ovf} !== 10'b0) begin
      fails++;
      $display("FAIL async_reset got %b want %b", {busy, dp, seg, ovf}, 10'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      tests++;
      if ({busy, dp, seg} !== 9'b0) begin
        fails++;
        $display("FAIL pending_dropped cycle %0d got %b want %b", i, {busy, dp, seg}, 9'b0);
      end
    end
  endtask

`ifdef DIV_SEQ_REPEAT_EN
  task automatic test_repeat();
    do_reset();
    for (int i = 0; i < 48; i++) begin
      if (i == 0) begin
        res_in = 8'h73; res_valid = 1'b1;
        push_seq(8'h73); push_seq(8'h73); push_seq(8'h73);
      end
      if (i == 26) begin
        res_in = 8'hFF; res_valid = 1'b1;
        push_seq(8'hFF); push_seq(8'hFF);
      end
      @(negedge clk);
      res_valid = 1'b0;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'b0;
      tests++;
      if ({busy, dp, seg} !== exp) begin
        fails++;
        $display("FAIL repeat cycle %0d got %b want %b", i, {busy, dp, seg}, exp);
      end
    end
  endtask
`endif

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    res_in    = 8'h00;
    res_valid = 1'b0;
    test_reset();
`ifdef DIV_SEQ_REPEAT_EN
    test_repeat();
`else
    test_single();
    test_error();
    test_overwrite();
    test_back_to_back();
    test_ena_and_reset();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
